// File: rtl/vx_commit_unit_scalar_pkg.sv
// Shared commit-stage types: packet layout, stream indices and arbiter states.
`timescale 1ns/1ps

`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif

`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif

package VX_gpu_pkg;

    localparam int XLEN             = 32;
    localparam int NR_BITS          = 5;
    localparam int UUID_WIDTH       = 44;
    localparam int PC_WIDTH         = 32;
    localparam int COMMIT_LANES     = 4;
    localparam int COMMIT_PID_WIDTH = 1;
    localparam int NW_WIDTH         = `LOG2UP(`NUM_WARPS);

    // Commit stream indices, one per execute unit
    localparam int EX_ALU       = 0;
    localparam int EX_LSU       = 1;
    localparam int EX_FPU       = 2;
    localparam int EX_SFU       = 3;
    localparam int NUM_EX_UNITS = 4;

    // Commit packet, MSB first: uuid ... eop (eop is bit 0)
    typedef struct packed {
        logic [UUID_WIDTH-1:0]                   uuid;
        logic [NW_WIDTH-1:0]                     wid;
        logic [COMMIT_LANES-1:0]                 tmask;
        logic [PC_WIDTH-1:0]                     pc;
        logic                                    wb;
        logic [NR_BITS-1:0]                      rd;
        logic [COMMIT_LANES-1:0][XLEN-1:0]       data;
        logic [COMMIT_PID_WIDTH-1:0]             pid;
        logic                                    sop;
        logic                                    eop;
    } commit_pkt_t;

    // Width of one commit stream payload; matches the SFU response arbiter
    localparam int CDATAW = $bits(commit_pkt_t);

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/vx_commit_unit_scalar_arb.sv
// Round-robin commit arbiter that locks onto one stream for multi-packet instructions.
`timescale 1ns/1ps

module VX_commit_lock_arb
    import VX_gpu_pkg::*;
#(
    parameter int NUM_EX = NUM_EX_UNITS,
    localparam int IDX_W = `LOG2UP(NUM_EX)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_EX-1:0] req_valid,
    input  logic [NUM_EX-1:0] req_sop,
    input  logic [NUM_EX-1:0] req_eop,
    output logic              grant_valid,
    output logic [IDX_W-1:0]  grant_idx,
    output logic [NUM_EX-1:0] grant_onehot,
    output logic              locked
);

    arb_state_e       state, next_state;
    logic [IDX_W-1:0] ptr, next_ptr;
    logic [IDX_W-1:0] lock_idx, next_lock_idx;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [31:0] v);
        return IDX_W'(v % NUM_EX);
    endfunction

    // Pick the winner and the next pointer/lock; nothing is granted while in reset
    always_comb begin
        next_state    = state;
        next_ptr      = ptr;
        next_lock_idx = lock_idx;
        grant_valid   = 1'b0;
        grant_idx     = '0;
        grant_onehot  = '0;
        if (!reset) begin
            case (state)
                ARB_IDLE: begin
                    for (int k = NUM_EX - 1; k >= 0; k--) begin
                        if (req_valid[wrap_idx(32'(ptr) + $unsigned(k))]) begin
                            grant_valid = 1'b1;
                            grant_idx   = wrap_idx(32'(ptr) + $unsigned(k));
                        end
                    end
                    if (grant_valid) begin
                        if (req_sop[grant_idx] && !req_eop[grant_idx]) begin
                            next_state    = ARB_LOCKED;
                            next_lock_idx = grant_idx;
                        end
                        if (req_eop[grant_idx]) begin
                            next_ptr = wrap_idx(32'(grant_idx) + 32'd1);
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (req_valid[lock_idx]) begin
                        grant_valid = 1'b1;
                        grant_idx   = lock_idx;
                        if (req_eop[lock_idx]) begin
                            next_state = ARB_IDLE;
                            next_ptr   = wrap_idx(32'(lock_idx) + 32'd1);
                        end
                    end
                end
                default: next_state = ARB_IDLE;
            endcase
            if (grant_valid) begin
                grant_onehot[grant_idx] = 1'b1;
            end
        end
    end

    // Arbiter state, priority pointer and locked stream
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            ptr      <= '0;
            lock_idx <= '0;
        end else begin
            state    <= next_state;
            ptr      <= next_ptr;
            lock_idx <= next_lock_idx;
        end
    end

    assign locked = (state == ARB_LOCKED);

endmodule

// File: rtl/vx_commit_unit_scalar.sv
// Scalar commit unit: merges the execute-unit commit streams into one
// register-file write port plus retire pulses and the instret counter.
`timescale 1ns/1ps

module vx_commit_unit_scalar
    import VX_gpu_pkg::*;
#(
    parameter int NUM_EX    = NUM_EX_UNITS,
    parameter int NUM_LANES = COMMIT_LANES,
    parameter int WARP_CNT  = `NUM_WARPS,
    parameter int PID_WIDTH = COMMIT_PID_WIDTH,
    localparam int WARP_CNT_WIDTH = `LOG2UP(WARP_CNT),
    localparam int IDX_W          = `LOG2UP(NUM_EX),
    localparam int DATAW          = NUM_LANES * XLEN
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_EX-1:0]                commit_valid_in,
    output logic [NUM_EX-1:0]                commit_ready_in,
    input  logic [NUM_EX-1:0][CDATAW-1:0]    commit_data_in,
    output logic                             wb_valid,
    output logic [WARP_CNT_WIDTH-1:0]        wb_wid,
    output logic [NR_BITS-1:0]               wb_rd,
    output logic [NUM_LANES-1:0]             wb_tmask,
    output logic [PID_WIDTH-1:0]             wb_pid,
    output logic [DATAW-1:0]                 wb_data,
    output logic                             retire_valid,
    output logic [WARP_CNT_WIDTH-1:0]        retire_wid,
    output logic [63:0]                      instret,
    output logic                             busy
);

    commit_pkt_t       in_pkt [NUM_EX];
    commit_pkt_t       sel_pkt;
    logic [NUM_EX-1:0] sop_vec;
    logic [NUM_EX-1:0] eop_vec;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic              arb_locked;
    logic              out_active;
    logic              unused_fields;

    for (genvar g = 0; g < NUM_EX; g++) begin : g_unpack
        assign in_pkt[g]  = commit_pkt_t'(commit_data_in[g]);
        assign sop_vec[g] = in_pkt[g].sop;
        assign eop_vec[g] = in_pkt[g].eop;
    end

    VX_commit_lock_arb #(
        .NUM_EX (NUM_EX)
    ) arb (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (commit_valid_in),
        .req_sop      (sop_vec),
        .req_eop      (eop_vec),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (commit_ready_in),
        .locked       (arb_locked)
    );

    assign sel_pkt       = in_pkt[grant_idx];
    assign unused_fields = ^{sel_pkt.uuid, sel_pkt.pc};

    // Output-stage strobes: one cycle after the handshake, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            out_active   <= 1'b0;
            wb_valid     <= 1'b0;
            retire_valid <= 1'b0;
        end else begin
            out_active   <= grant_valid;
            wb_valid     <= grant_valid && sel_pkt.wb && (|sel_pkt.tmask);
            retire_valid <= grant_valid && sel_pkt.eop;
        end
    end

    // Output-stage payload, only meaningful alongside the strobes above
    always_ff @(posedge clk) begin
        if (grant_valid) begin
            wb_wid     <= WARP_CNT_WIDTH'(sel_pkt.wid);
            wb_rd      <= sel_pkt.rd;
            wb_tmask   <= NUM_LANES'(sel_pkt.tmask);
            wb_pid     <= PID_WIDTH'(sel_pkt.pid);
            wb_data    <= DATAW'(sel_pkt.data);
            retire_wid <= WARP_CNT_WIDTH'(sel_pkt.wid);
        end
    end

    // Retired-instruction counter, wraps naturally at 2^64
    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= '0;
        end else if (retire_valid) begin
            instret <= instret + 64'd1;
        end
    end

    assign busy = !reset && (out_active || arb_locked);

endmodule

// File: tb/tb_vx_commit_unit_scalar.sv
// Directed self-checking bench for the scalar commit unit.
`timescale 1ns/1ps

module tb_vx_commit_unit_scalar;
    import VX_gpu_pkg::*;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [3:0]                  commit_valid_in;
    logic [3:0]                  commit_ready_in;
    logic [3:0][CDATAW-1:0]      commit_data_in;
    logic                        wb_valid;
    logic [1:0]                  wb_wid;
    logic [4:0]                  wb_rd;
    logic [3:0]                  wb_tmask;
    logic [0:0]                  wb_pid;
    logic [127:0]                wb_data;
    logic                        retire_valid;
    logic [1:0]                  retire_wid;
    logic [63:0]                 instret;
    logic                        busy;

    int checks   = 0;
    int failures = 0;

    vx_commit_unit_scalar dut (
        .clk             (clk),
        .reset           (reset),
        .commit_valid_in (commit_valid_in),
        .commit_ready_in (commit_ready_in),
        .commit_data_in  (commit_data_in),
        .wb_valid        (wb_valid),
        .wb_wid          (wb_wid),
        .wb_rd           (wb_rd),
        .wb_tmask        (wb_tmask),
        .wb_pid          (wb_pid),
        .wb_data         (wb_data),
        .retire_valid    (retire_valid),
        .retire_wid      (retire_wid),
        .instret         (instret),
        .busy            (busy)
    );

    // 10 ns clock; stimulus changes on negedge, outputs sampled 1 ns later
    always #5 clk = ~clk;

    // Stop a runaway simulation
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    function automatic logic [CDATAW-1:0] mk_pkt(input logic [1:0] wid, input logic [3:0] tmask,
                                                 input logic wb, input logic [4:0] rd,
                                                 input logic [127:0] d, input logic pid,
                                                 input logic sop, input logic eop);
        commit_pkt_t p;
        p.uuid  = 44'h123;
        p.wid   = wid;
        p.tmask = tmask;
        p.pc    = 32'h8000_0000;
        p.wb    = wb;
        p.rd    = rd;
        p.data  = d;
        p.pid   = pid;
        p.sop   = sop;
        p.eop   = eop;
        return p;
    endfunction

    // Reset quiets everything; the first cycle out of reset can already grant
    task automatic test_reset();
        reset           = 1'b1;
        commit_valid_in = 4'b1111;
        for (int i = 0; i < 4; i++)
            commit_data_in[i] = mk_pkt(2'(i), 4'hF, 1'b0, 5'd0, '0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (commit_ready_in !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0000", commit_ready_in); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb_valid: got %b expected 0", wb_valid); end
        checks++; if (retire_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_retire: got %b expected 0", retire_valid); end
        checks++; if (instret !== 64'd0) begin failures++; $display("[TB] FAIL reset_instret: got %0d expected 0", instret); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        #1;
        checks++; if (commit_ready_in !== 4'b0001) begin failures++; $display("[TB] FAIL first_grant: got %b expected 0001", commit_ready_in); end
        commit_valid_in = 4'b0000;
    endtask

    // All four streams ready with single-packet instructions
    task automatic test_round_robin();
        logic [3:0] exp_ready;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                for (int i = 0; i < 4; i++)
                    commit_data_in[i] = mk_pkt(2'(i), 4'hF, 1'b1, 5'(i + 1), '0, 1'b0, 1'b1, 1'b1);
                commit_valid_in = 4'b1111;
            end
            #1;
            exp_ready = 4'b0001 << (k % 4);
            checks++; if (commit_ready_in !== exp_ready) begin failures++; $display("[TB] FAIL rr_ready%0d: got %b expected %b", k, commit_ready_in, exp_ready); end
            if (k > 0) begin
                checks++; if (retire_valid !== 1'b1 || retire_wid !== 2'((k - 1) % 4)) begin failures++; $display("[TB] FAIL rr_retire%0d: got %b/%0d expected 1/%0d", k, retire_valid, retire_wid, (k - 1) % 4); end
                checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'(((k - 1) % 4) + 1)) begin failures++; $display("[TB] FAIL rr_wb%0d: got %b/%0d expected 1/%0d", k, wb_valid, wb_rd, ((k - 1) % 4) + 1); end
            end
        end
        @(negedge clk);
        commit_valid_in = 4'b0000;
        #1;
        checks++; if (retire_valid !== 1'b1 || retire_wid !== 2'd0) begin failures++; $display("[TB] FAIL rr_retire_last: got %b/%0d expected 1/0", retire_valid, retire_wid); end
        checks++; if (instret !== 64'd4) begin failures++; $display("[TB] FAIL rr_instret4: got %0d expected 4", instret); end
        @(negedge clk); #1;
        checks++; if (instret !== 64'd5) begin failures++; $display("[TB] FAIL rr_instret5: got %0d expected 5", instret); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rr_busy_idle: got %b expected 0", busy); end
    endtask

    // Stream 2 sends a three-packet instruction while streams 0 and 1 compete
    task automatic test_lock();
        logic [3:0] exp_ready [5];
        logic       exp_ret   [5];
        logic [1:0] exp_wid   [5];
        logic       exp_busy  [5];
        logic       exp_pid   [5];
        int         retire_seen;
        exp_ready   = '{4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
        exp_ret     = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_wid     = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd3};
        exp_busy    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_pid     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        retire_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            commit_data_in[0] = mk_pkt(2'd0, 4'hF, 1'b0, 5'd0, '0, 1'b0, 1'b1, 1'b1);
            commit_data_in[1] = mk_pkt(2'd1, 4'hF, 1'b0, 5'd0, '0, 1'b0, 1'b1, 1'b1);
            case (c)
                0, 1:    commit_data_in[2] = mk_pkt(2'd3, 4'hF, 1'b1, 5'd7, '0, 1'b0, 1'b1, 1'b0);
                2:       commit_data_in[2] = mk_pkt(2'd3, 4'hF, 1'b1, 5'd7, '0, 1'b1, 1'b0, 1'b0);
                3:       commit_data_in[2] = mk_pkt(2'd3, 4'hF, 1'b1, 5'd7, '0, 1'b0, 1'b0, 1'b1);
                default: commit_data_in[2] = '0;
            endcase
            commit_valid_in = (c < 4) ? 4'b0111 : 4'b0011;
            #1;
            checks++; if (commit_ready_in !== exp_ready[c]) begin failures++; $display("[TB] FAIL lock_ready%0d: got %b expected %b", c, commit_ready_in, exp_ready[c]); end
            checks++; if (retire_valid !== exp_ret[c]) begin failures++; $display("[TB] FAIL lock_retire%0d: got %b expected %b", c, retire_valid, exp_ret[c]); end
            if (exp_ret[c]) begin
                checks++; if (retire_wid !== exp_wid[c]) begin failures++; $display("[TB] FAIL lock_retire_wid%0d: got %0d expected %0d", c, retire_wid, exp_wid[c]); end
            end
            checks++; if (busy !== exp_busy[c]) begin failures++; $display("[TB] FAIL lock_busy%0d: got %b expected %b", c, busy, exp_busy[c]); end
            if (c >= 2) begin
                checks++; if (wb_valid !== 1'b1 || wb_pid !== exp_pid[c]) begin failures++; $display("[TB] FAIL lock_wb_pid%0d: got %b/%0d expected 1/%0d", c, wb_valid, wb_pid, exp_pid[c]); end
                if (retire_valid) retire_seen++;
            end
        end
        @(negedge clk);
        commit_valid_in = 4'b0000;
        #1;
        checks++; if (retire_valid !== 1'b1 || retire_wid !== 2'd0) begin failures++; $display("[TB] FAIL lock_after: got %b/%0d expected 1/0", retire_valid, retire_wid); end
        checks++; if (retire_seen != 1) begin failures++; $display("[TB] FAIL lock_retire_count: got %0d expected 1", retire_seen); end
    endtask

    // No write-back flag, then an all-zero thread mask: both retire, neither writes
    task automatic test_no_writeback();
        @(negedge clk);
        commit_data_in[1] = mk_pkt(2'd1, 4'hF, 1'b0, 5'd9, '1, 1'b0, 1'b1, 1'b1);
        commit_valid_in   = 4'b0010;
        #1;
        checks++; if (commit_ready_in !== 4'b0010) begin failures++; $display("[TB] FAIL nowb_ready: got %b expected 0010", commit_ready_in); end
        @(negedge clk);
        commit_data_in[2] = mk_pkt(2'd2, 4'h0, 1'b1, 5'd3, '1, 1'b0, 1'b1, 1'b1);
        commit_valid_in   = 4'b0100;
        #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL nowb_wb_valid: got %b expected 0", wb_valid); end
        checks++; if (retire_valid !== 1'b1 || retire_wid !== 2'd1) begin failures++; $display("[TB] FAIL nowb_retire: got %b/%0d expected 1/1", retire_valid, retire_wid); end
        checks++; if (commit_ready_in !== 4'b0100) begin failures++; $display("[TB] FAIL zmask_ready: got %b expected 0100", commit_ready_in); end
        @(negedge clk);
        commit_valid_in = 4'b0000;
        #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL zmask_wb_valid: got %b expected 0", wb_valid); end
        checks++; if (retire_valid !== 1'b1 || retire_wid !== 2'd2) begin failures++; $display("[TB] FAIL zmask_retire: got %b/%0d expected 1/2", retire_valid, retire_wid); end
    endtask

    // Partial thread mask with per-lane data
    task automatic test_writeback();
        logic [127:0] lanes;
        lanes = {32'hD, 32'hC, 32'hB, 32'hA};
        @(negedge clk);
        commit_data_in[3] = mk_pkt(2'd2, 4'b0101, 1'b1, 5'd5, lanes, 1'b1, 1'b1, 1'b1);
        commit_valid_in   = 4'b1000;
        #1;
        checks++; if (commit_ready_in !== 4'b1000) begin failures++; $display("[TB] FAIL wb_ready: got %b expected 1000", commit_ready_in); end
        @(negedge clk);
        commit_valid_in = 4'b0000;
        #1;
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("[TB] FAIL wb_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_rd !== 5'd5) begin failures++; $display("[TB] FAIL wb_rd: got %0d expected 5", wb_rd); end
        checks++; if (wb_tmask !== 4'b0101) begin failures++; $display("[TB] FAIL wb_tmask: got %b expected 0101", wb_tmask); end
        checks++; if (wb_data !== 128'h0000000D_0000000C_0000000B_0000000A) begin failures++; $display("[TB] FAIL wb_data: got %h expected 0000000d0000000c0000000b0000000a", wb_data); end
        checks++; if (wb_wid !== 2'd2 || wb_pid !== 1'b1) begin failures++; $display("[TB] FAIL wb_wid_pid: got %0d/%0d expected 2/1", wb_wid, wb_pid); end
        checks++; if (retire_valid !== 1'b1) begin failures++; $display("[TB] FAIL wb_retire: got %b expected 1", retire_valid); end
    endtask

    // No valid input, then a locked stream that stalls mid-instruction
    task automatic test_idle_hold();
        @(negedge clk);
        commit_valid_in = 4'b0000;
        #1;
        checks++; if (commit_ready_in !== 4'b0000) begin failures++; $display("[TB] FAIL idle_ready: got %b expected 0000", commit_ready_in); end
        @(negedge clk); #1;
        checks++; if (wb_valid !== 1'b0 || retire_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_out: got %b%b%b expected 000", wb_valid, retire_valid, busy); end
        commit_data_in[0] = mk_pkt(2'd0, 4'hF, 1'b1, 5'd1, '0, 1'b0, 1'b1, 1'b0);
        commit_valid_in   = 4'b0001;
        #1;
        checks++; if (commit_ready_in !== 4'b0001) begin failures++; $display("[TB] FAIL hold_lock_ready: got %b expected 0001", commit_ready_in); end
        @(negedge clk);
        commit_data_in[1] = mk_pkt(2'd1, 4'hF, 1'b1, 5'd2, '0, 1'b0, 1'b1, 1'b1);
        commit_valid_in   = 4'b0010;
        #1;
        checks++; if (commit_ready_in !== 4'b0000) begin failures++; $display("[TB] FAIL hold_stall_ready: got %b expected 0000", commit_ready_in); end
        checks++; if (wb_valid !== 1'b1 || retire_valid !== 1'b0) begin failures++; $display("[TB] FAIL hold_first_pkt: got %b/%b expected 1/0", wb_valid, retire_valid); end
        @(negedge clk);
        commit_data_in[0] = mk_pkt(2'd0, 4'hF, 1'b1, 5'd1, '0, 1'b1, 1'b0, 1'b1);
        commit_valid_in   = 4'b0011;
        #1;
        checks++; if (wb_valid !== 1'b0 || retire_valid !== 1'b0) begin failures++; $display("[TB] FAIL hold_stall_out: got %b/%b expected 0/0", wb_valid, retire_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL hold_busy: got %b expected 1", busy); end
        checks++; if (commit_ready_in !== 4'b0001) begin failures++; $display("[TB] FAIL hold_resume_ready: got %b expected 0001", commit_ready_in); end
        @(negedge clk);
        commit_valid_in = 4'b0000;
        #1;
        checks++; if (retire_valid !== 1'b1 || retire_wid !== 2'd0) begin failures++; $display("[TB] FAIL hold_retire: got %b/%0d expected 1/0", retire_valid, retire_wid); end
    endtask

    // Reset in the middle of a locked instruction on stream 1
    task automatic test_reset_mid_lock();
        @(negedge clk);
        commit_data_in[1] = mk_pkt(2'd1, 4'hF, 1'b1, 5'd4, '0, 1'b0, 1'b1, 1'b0);
        commit_valid_in   = 4'b0010;
        #1;
        checks++; if (commit_ready_in !== 4'b0010) begin failures++; $display("[TB] FAIL rml_lock_ready: got %b expected 0010", commit_ready_in); end
        @(negedge clk);
        reset             = 1'b1;
        commit_data_in[0] = mk_pkt(2'd0, 4'hF, 1'b0, 5'd0, '0, 1'b0, 1'b1, 1'b1);
        commit_data_in[1] = mk_pkt(2'd1, 4'hF, 1'b1, 5'd4, '0, 1'b1, 1'b0, 1'b1);
        commit_valid_in   = 4'b0011;
        #1;
        checks++; if (commit_ready_in !== 4'b0000) begin failures++; $display("[TB] FAIL rml_reset_ready: got %b expected 0000", commit_ready_in); end
        checks++; if (retire_valid !== 1'b0) begin failures++; $display("[TB] FAIL rml_partial_retire: got %b expected 0", retire_valid); end
        @(negedge clk); #1;
        checks++; if (instret !== 64'd0 || retire_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rml_cleared: got %0d/%b/%b expected 0/0/0", instret, retire_valid, busy); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            commit_data_in[i] = mk_pkt(2'(i), 4'hF, 1'b0, 5'd0, '0, 1'b0, 1'b1, 1'b1);
        commit_valid_in = 4'b0111;
        #1;
        checks++; if (commit_ready_in !== 4'b0001) begin failures++; $display("[TB] FAIL rml_rr_restart: got %b expected 0001", commit_ready_in); end
        @(negedge clk);
        commit_valid_in = 4'b0000;
        #1;
        checks++; if (retire_valid !== 1'b1 || retire_wid !== 2'd0) begin failures++; $display("[TB] FAIL rml_retire: got %b/%0d expected 1/0", retire_valid, retire_wid); end
        @(negedge clk); #1;
        checks++; if (instret !== 64'd1) begin failures++; $display("[TB] FAIL rml_instret: got %0d expected 1", instret); end
    endtask

    // Counter at its maximum wraps to zero on the next retire
    task automatic test_instret_wrap();
        @(negedge clk);
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret;
        commit_data_in[1] = mk_pkt(2'd1, 4'hF, 1'b0, 5'd0, '0, 1'b0, 1'b1, 1'b1);
        commit_valid_in   = 4'b0010;
        #1;
        checks++; if (commit_ready_in !== 4'b0010) begin failures++; $display("[TB] FAIL wrap_ready: got %b expected 0010", commit_ready_in); end
        @(negedge clk);
        commit_valid_in = 4'b0000;
        #1;
        checks++; if (retire_valid !== 1'b1 || instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("[TB] FAIL wrap_pre: got %b/%h expected 1/ffffffffffffffff", retire_valid, instret); end
        @(negedge clk); #1;
        checks++; if (instret !== 64'd0) begin failures++; $display("[TB] FAIL wrap_zero: got %h expected 0", instret); end
    endtask

    // Run every scenario in order, then report
    initial begin
        reset           = 1'b1;
        commit_valid_in = '0;
        commit_data_in  = '0;
        test_reset();
        test_round_robin();
        test_lock();
        test_no_writeback();
        test_writeback();
        test_idle_hold();
        test_reset_mid_lock();
        test_instret_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
